// File: rtl/asynchronous_fifo_stream_reader_pkg.sv
// Shared types for the asynchronous FIFO stream reader: FSM states, the default
// last-flag position and the layout of a buffered word.
package asynchronous_fifo_stream_reader_pkg;

    typedef enum logic {
        PASS    = 1'b0,
        DISCARD = 1'b1
    } state_t;

    localparam int DATA_WIDTH_DEFAULT = 16;
    localparam int LAST_BIT           = DATA_WIDTH_DEFAULT;

    // Matches the FIFO word layout: last-of-frame flag above the payload.
    typedef struct packed {
        logic                          last;
        logic [DATA_WIDTH_DEFAULT-1:0] data;
    } entry_t;

endpackage

// File: rtl/asynchronous_fifo_stream_reader_buffer.sv
// Small single-clock register FIFO that absorbs the FIFO read latency.
// Head word is presented combinationally; push and pop may coincide at any fill level.
module stream_reader_buffer #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     empty
);
    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (occupancy == '0);

endmodule

// File: rtl/asynchronous_fifo_stream_reader.sv
// Read-domain stream reader for an asynchronous FIFO: credit-limited read issue, latency
// buffer, valid/ready output and head-frame discard. ASYNCHRONOUS_FIFO_STREAM_READER_STATS_EN
// enables the frame/drop counters; without it both counter outputs read 0.
//
//   state   | meaning
//   PASS    | buffer head is offered on the output stream
//   DISCARD | head words are popped unseen until a last-of-frame word leaves
module asynchronous_fifo_stream_reader
    import asynchronous_fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int BUFFER_DEPTH = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH:0]    fifo_read_data,
    input  logic                   fifo_read_data_valid,
    output logic                   fifo_read_enable,
    output logic [DATA_WIDTH-1:0]  output_data,
    output logic                   output_last,
    output logic                   output_valid,
    input  logic                   output_ready,
    input  logic                   drop_frame,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic [COUNT_WIDTH-1:0] drop_count,
    output logic                   busy
);
    localparam int OCC_WIDTH = $clog2(BUFFER_DEPTH) + 1;

    logic [READ_LATENCY-1:0] issued;
    logic [OCC_WIDTH-1:0]    inflight;
    logic [OCC_WIDTH-1:0]    occupancy;
    logic [OCC_WIDTH:0]      credit_used;
    logic                    buffer_empty;
    logic [DATA_WIDTH:0]     head;
    logic                    head_last;
    logic                    transfer;
    logic                    pop;
    state_t                  state;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + OCC_WIDTH'(issued[i]);
        end
    end

    // Credits ignore a same-cycle pop, so a word in flight always has a slot waiting.
    assign credit_used      = {1'b0, occupancy} + {1'b0, inflight};
    assign fifo_read_enable = !reset && !fifo_empty
                              && (credit_used < (OCC_WIDTH + 1)'(BUFFER_DEPTH));

    // A slot that shifts out without a returned word just releases its credit.
    always_ff @(posedge clock) begin
        if (reset) begin
            issued <= '0;
        end else begin
            issued <= READ_LATENCY'({issued, fifo_read_enable});
        end
    end

    stream_reader_buffer #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (BUFFER_DEPTH)
    ) u_buffer (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_read_data_valid),
        .push_data (fifo_read_data),
        .pop       (pop),
        .head      (head),
        .occupancy (occupancy),
        .empty     (buffer_empty)
    );

    assign head_last    = head[DATA_WIDTH];
    assign output_valid = !buffer_empty && (state == PASS);
    assign output_data  = buffer_empty ? '0 : head[DATA_WIDTH-1:0];
    assign output_last  = !buffer_empty && head_last;
    assign transfer     = output_valid && output_ready;
    assign pop          = transfer || ((state == DISCARD) && !buffer_empty);
    assign busy         = !buffer_empty || (inflight != '0) || (state == DISCARD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= PASS;
        end else begin
            case (state)
                PASS: begin
                    if (drop_frame) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (!buffer_empty && head_last) begin
                        state <= PASS;
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

`ifdef ASYNCHRONOUS_FIFO_STREAM_READER_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (transfer && head_last) begin
                frame_count <= frame_count + 1'b1;
            end
            if ((state == DISCARD) && !buffer_empty && head_last) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end
`else
    assign frame_count = '0;
    assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_asynchronous_fifo_stream_reader.sv
// Directed bench: two readers (read latency 1 and 2) fed by behavioural FIFO read ports.
module tb_asynchronous_fifo_stream_reader;
    import asynchronous_fifo_stream_reader_pkg::*;

`ifdef ASYNCHRONOUS_FIFO_STREAM_READER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    typedef struct {
        entry_t w;
        int     cyc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst, ready, drop, fake_nonempty;
    logic        a_empty, a_rvalid, a_ren, a_olast, a_ovalid, a_busy;
    logic [16:0] a_rdata;
    logic [15:0] a_odata, a_fc, a_dc;
    logic        b_empty, b_rvalid, b_ren, b_olast, b_ovalid, b_busy, b_p1v;
    logic [16:0] b_rdata, b_p1;
    logic [15:0] b_odata, b_fc, b_dc;

    entry_t fmem [0:255];
    int     wr_idx = 0, a_rd = 0, b_rd = 0, cyc = 0;
    int     n_cmp = 0, n_bad = 0;
    int     a_first_ren = -1, a_first_ov = -1, b_first_ren = -1, b_first_ov = -1;
    int     outst = 0, max_out = 0, viol = 0;
    logic   win = 1'b0;
    rec_t   a_log[$], b_log[$];
    rec_t   ra, rb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    asynchronous_fifo_stream_reader #(
        .DATA_WIDTH(16), .READ_LATENCY(1), .BUFFER_DEPTH(4), .COUNT_WIDTH(16)
    ) dut_a (
        .clock(clk), .reset(rst), .fifo_empty(a_empty), .fifo_read_data(a_rdata),
        .fifo_read_data_valid(a_rvalid), .fifo_read_enable(a_ren), .output_data(a_odata),
        .output_last(a_olast), .output_valid(a_ovalid), .output_ready(ready),
        .drop_frame(drop), .frame_count(a_fc), .drop_count(a_dc), .busy(a_busy)
    );

    asynchronous_fifo_stream_reader #(
        .DATA_WIDTH(16), .READ_LATENCY(2), .BUFFER_DEPTH(4), .COUNT_WIDTH(16)
    ) dut_b (
        .clock(clk), .reset(rst), .fifo_empty(b_empty), .fifo_read_data(b_rdata),
        .fifo_read_data_valid(b_rvalid), .fifo_read_enable(b_ren), .output_data(b_odata),
        .output_last(b_olast), .output_valid(b_ovalid), .output_ready(ready),
        .drop_frame(drop), .frame_count(b_fc), .drop_count(b_dc), .busy(b_busy)
    );

    // FIFO read-port models; a read against an empty model returns no strobe.
    assign a_empty = (a_rd == wr_idx) && !fake_nonempty;
    assign b_empty = (b_rd == wr_idx);

    always @(posedge clk) begin
        if (rst) begin
            a_rd <= wr_idx; a_rvalid <= 1'b0;
            b_rd <= wr_idx; b_p1v <= 1'b0; b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= 1'b0;
            if (a_ren && a_rd != wr_idx) begin
                a_rdata <= fmem[a_rd]; a_rvalid <= 1'b1; a_rd <= a_rd + 1;
            end
            b_p1v <= 1'b0;
            if (b_ren && b_rd != wr_idx) begin
                b_p1 <= fmem[b_rd]; b_p1v <= 1'b1; b_rd <= b_rd + 1;
            end
            b_rvalid <= b_p1v;
            b_rdata  <= b_p1;
        end
    end

    always @(negedge clk) begin
        if (a_ovalid && ready) begin ra.w = {a_olast, a_odata}; ra.cyc = cyc; a_log.push_back(ra); end
        if (b_ovalid && ready) begin rb.w = {b_olast, b_odata}; rb.cyc = cyc; b_log.push_back(rb); end
        if (a_ren && a_first_ren < 0) a_first_ren = cyc;
        if (a_ovalid && a_first_ov < 0) a_first_ov = cyc;
        if (b_ren && b_first_ren < 0) b_first_ren = cyc;
        if (b_ovalid && b_first_ov < 0) b_first_ov = cyc;
        if (win) begin
            if (a_ren !== (!a_empty && (outst < 4))) viol++;
            if (outst > max_out) max_out = outst;
            outst = outst + (a_ren ? 1 : 0) - ((a_ovalid && ready) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t mkw(input logic [15:0] base, input int i, input int flen);
        entry_t e;
        e.data = base + 16'(i);
        e.last = ((i % flen) == flen - 1);
        return e;
    endfunction

    task automatic load(input logic [15:0] base, input int n, input int flen);
        for (int i = 0; i < n; i++) begin
            fmem[wr_idx] = mkw(base, i, flen);
            wr_idx++;
        end
    endtask

    task automatic check_words(input string tag, input int sel, input int start,
                               input logic [15:0] base, input int n, input int flen);
        for (int k = 0; k < n; k++) begin
            if (sel == 0 && start + k < a_log.size())
                check($sformatf("%s_w%0d", tag, k), 32'(a_log[start + k].w), 32'(mkw(base, k, flen)));
            if (sel == 1 && start + k < b_log.size())
                check($sformatf("%s_w%0d", tag, k), 32'(b_log[start + k].w), 32'(mkw(base, k, flen)));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_log.delete();
        b_log.delete();
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; drop = 1'b0; fake_nonempty = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_valid", 32'(a_ovalid), 0);
        check("rst_ren",   32'(a_ren), 0);
        check("rst_busy",  32'(a_busy), 0);
        check("rst_data",  32'(a_odata), 0);
        check("rst_last",  32'(a_olast), 0);
        check("rst_fc",    32'(a_fc), 0);
        check("rst_dc",    32'(a_dc), 0);

        // Sustained flow, both latencies.
        ready = 1'b1;
        load(16'h1000, 64, 8);
        for (int i = 0; i < 150 && a_log.size() < 64; i++) tick();
        repeat (5) tick();
        check("t1_a_count", 32'(a_log.size()), 64);
        check("t1_b_count", 32'(b_log.size()), 64);
        check_words("t1_a", 0, 0, 16'h1000, 64, 8);
        check_words("t1_b", 1, 0, 16'h1000, 64, 8);
        if (a_log.size() == 64) check("t1_a_span", 32'(a_log[63].cyc - a_log[0].cyc), 63);
        if (b_log.size() == 64) check("t1_b_span", 32'(b_log[63].cyc - b_log[0].cyc), 63);
        check("t1_a_lat", 32'(a_first_ov - a_first_ren), 2);
        check("t1_b_lat", 32'(b_first_ov - b_first_ren), 3);
        check("t1_a_fc", 32'(a_fc), STATS ? 8 : 0);
        check("t1_b_fc", 32'(b_fc), STATS ? 8 : 0);
        check("t1_a_busy", 32'(a_busy), 0);
        check("t1_b_busy", 32'(b_busy), 0);

        // Backpressure: ready alternates every cycle.
        do_reset();
        outst = 0; max_out = 0; viol = 0; win = 1'b1;
        load(16'h2000, 32, 8);
        for (int i = 0; i < 200 && a_log.size() < 32; i++) begin
            ready = !ready;
            tick();
        end
        win = 1'b0; ready = 1'b1;
        repeat (4) tick();
        check("t2_count", 32'(a_log.size()), 32);
        check_words("t2", 0, 0, 16'h2000, 32, 8);
        check("t2_max_outstanding", 32'(max_out), 4);
        check("t2_ren_rule_errors", 32'(viol), 0);

        // Drop after three words of frame 1.
        do_reset();
        ready = 1'b0;
        load(16'h3100, 8, 8);
        load(16'h3200, 8, 8);
        repeat (6) tick();
        ready = 1'b1;
        repeat (3) tick();
        ready = 1'b0; drop = 1'b1;
        tick();
        drop = 1'b0;
        check("t3_discard_valid", 32'(a_ovalid), 0);
        ready = 1'b1;
        for (int i = 0; i < 60 && a_log.size() < 11; i++) tick();
        repeat (5) tick();
        check("t3_count", 32'(a_log.size()), 11);
        check_words("t3_f1", 0, 0, 16'h3100, 3, 8);
        check_words("t3_f2", 0, 3, 16'h3200, 8, 8);
        check("t3_fc", 32'(a_fc), STATS ? 1 : 0);
        check("t3_dc", 32'(a_dc), STATS ? 1 : 0);

        // Drop on the cycle frame 1's last word transfers.
        do_reset();
        ready = 1'b0;
        load(16'h4100, 8, 8);
        load(16'h4200, 8, 8);
        repeat (6) tick();
        ready = 1'b1;
        repeat (7) tick();
        drop = 1'b1;
        tick();
        drop = 1'b0;
        repeat (40) tick();
        check("t4_count", 32'(a_log.size()), 8);
        check_words("t4_f1", 0, 0, 16'h4100, 8, 8);
        check("t4_fc", 32'(a_fc), STATS ? 1 : 0);
        check("t4_dc", 32'(a_dc), STATS ? 1 : 0);
        check("t4_busy", 32'(a_busy), 0);

        // Read issued against a FIFO that turns out empty.
        fake_nonempty = 1'b1;
        #1;
        check("t5_ren", 32'(a_ren), 1);
        tick();
        fake_nonempty = 1'b0;
        check("t5_busy_inflight", 32'(a_busy), 1);
        tick();
        check("t5_busy_released", 32'(a_busy), 0);
        check("t5_valid", 32'(a_ovalid), 0);

        // Reset with three words buffered.
        ready = 1'b0;
        a_log.delete();
        load(16'h6000, 3, 3);
        repeat (4) tick();
        check("t6_pre_valid", 32'(a_ovalid), 1);
        check("t6_pre_data", 32'(a_odata), 32'h6000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", 32'(a_ovalid), 0);
        check("t6_busy", 32'(a_busy), 0);
        check("t6_data", 32'(a_odata), 0);
        check("t6_fc", 32'(a_fc), 0);
        check("t6_dc", 32'(a_dc), 0);
        ready = 1'b1;
        repeat (5) tick();
        check("t6_no_leak", 32'(a_log.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
